// File: rtl/gpu_pkg.sv
// Shared GPU datapath constants: FMA array geometry, fixed-point format and
// the phrase/line packing used between the FMA array and the memory block.
package gpu_pkg;

  localparam int WORD_WIDTH       = 16;
  localparam int FMA_COUNT        = 2;
  localparam int FIXED_POINT      = 10;
  localparam int PHRASES_PER_LINE = 3;
  localparam int LINE_WIDTH       = PHRASES_PER_LINE * FMA_COUNT * WORD_WIDTH;

  // Bit offset of FMA i's word within phrase k of a line; phrase 0 is lowest.
  function automatic int phrase_lsb(input int k, input int i,
                                    input int fma_count  = FMA_COUNT,
                                    input int word_width = WORD_WIDTH);
    return k * fma_count * word_width + i * word_width;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Two-entry line queue with a registered head; a pop frees the slot for a
// push in the same cycle, so push+pop is accepted even when full.
module line_fifo #(
  parameter int WIDTH = 96
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] head_out,
  output logic             valid_out,
  output logic             full_out
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop_in && (count_q != 2'd0);
  assign do_push = push_in && ((count_q != 2'd2) || do_pop);

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (do_push) begin
          slot0_d = data_in;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (do_pop && do_push) begin
          slot0_d = data_in;
        end else if (do_pop) begin
          slot0_d = '0;
          count_d = 2'd0;
        end else if (do_push) begin
          slot1_d = data_in;
          count_d = 2'd2;
        end
      end
      default: begin
        if (do_pop) begin
          slot0_d = slot1_q;
          if (do_push) begin
            slot1_d = data_in;
          end else begin
            slot1_d = '0;
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  // NOTE: the queue storage is reset too, because the head drives the output
  // directly and must read as zero right after reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_out  = slot0_q;
  assign valid_out = (count_q != 2'd0);
  assign full_out  = (count_q == 2'd2);

endmodule

// File: rtl/fma_write_buffer.sv
// Packs successive FMA result phrases into lines of three for the memory
// block's LOADB path, queuing completed lines in a 2-entry buffer.
module fma_write_buffer #(
  parameter int FMA_COUNT  = gpu_pkg::FMA_COUNT,
  parameter int WORD_WIDTH = gpu_pkg::WORD_WIDTH,
  parameter int LINE_WIDTH = 3 * FMA_COUNT * WORD_WIDTH
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
  input  logic                            fma_valid_in,
  input  logic                            flush_in,
  input  logic                            consume_in,
  output logic [LINE_WIDTH-1:0]           write_buffer_read_out,
  output logic                            write_buffer_valid_out,
  output logic [1:0]                      phrase_count_out,
  output logic                            overflow_out
);

  import gpu_pkg::*;

  localparam int PHRASE_W = FMA_COUNT * WORD_WIDTH;

  if (LINE_WIDTH != PHRASES_PER_LINE * FMA_COUNT * WORD_WIDTH) begin : g_bad_line_width
    $error("fma_write_buffer: LINE_WIDTH must equal 3*FMA_COUNT*WORD_WIDTH");
  end

  logic [LINE_WIDTH-1:0] acc_q, acc_d;
  logic [LINE_WIDTH-1:0] line_w;
  logic [1:0]            cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  line_done;
  logic                  fifo_full;
  logic                  fifo_valid;

  // The incoming phrase is merged first so a same-cycle flush includes it;
  // unwritten phrases are already zero because acc clears on every completion.
  always_comb begin
    line_w = acc_q;
    for (int k = 0; k < PHRASES_PER_LINE; k++) begin
      if (fma_valid_in && (cnt_q == 2'(k))) begin
        line_w[phrase_lsb(k, 0, FMA_COUNT, WORD_WIDTH) +: PHRASE_W] = fma_c_in;
      end
    end
  end

  assign line_done = (fma_valid_in && (cnt_q == 2'(PHRASES_PER_LINE - 1)))
                   || (flush_in && ((cnt_q != 2'd0) || fma_valid_in));

  always_comb begin
    acc_d      = line_w;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (line_done) begin
      acc_d = '0;
      cnt_d = 2'd0;
      // A full queue only drops the line when nothing is leaving this cycle.
      if (fifo_full && !consume_in) begin
        overflow_d = 1'b1;
      end
    end else if (fma_valid_in) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q      <= '0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  line_fifo #(
    .WIDTH (LINE_WIDTH)
  ) u_line_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (line_done),
    .data_in   (line_w),
    .pop_in    (consume_in),
    .head_out  (write_buffer_read_out),
    .valid_out (fifo_valid),
    .full_out  (fifo_full)
  );

  assign write_buffer_valid_out = fifo_valid;
  assign phrase_count_out       = cnt_q;
  assign overflow_out           = overflow_q;

endmodule
